// File: rtl/pipe_mem_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the arbiter FSM state enum and default bus widths.
package pipe_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } arb_state_e;

endpackage

// File: rtl/arb_starve_guard.sv
// Fetch starvation guard for pipe_mem_arbiter (ARB_STARVE_GUARD_EN builds).
// Ports: clk, rst, grant_dm/grant_if (IDLE grants), if_req, force_if.
//   force_if : fetch must win the next IDLE arbitration if it is requesting.
module arb_starve_guard #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_dm,
    input  logic grant_if,
    input  logic if_req,
    output logic force_if
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // Counts data grants that overtook a waiting fetch. It cannot pass
    // STARVE_MAX: at that value a waiting fetch wins and clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant_if) begin
            cnt <= '0;
        end else if (grant_dm) begin
            cnt <= if_req ? cnt + 1'b1 : '0;
        end
    end

    assign force_if = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and memory stage.
// Ports: clk, rst (sync, active high); fetch port if_req/if_addr ->
//   if_rdata/if_ack; data port dm_req/dm_we/dm_addr/dm_wdata ->
//   dm_rdata/dm_ack; memory side mem_req/mem_we/mem_addr/mem_wdata <-
//   mem_rdata/mem_ready; stall_if/stall_mem to freeze the pipeline.
// Data port wins ties. Define ARB_STARVE_GUARD_EN to let a fetch win
// after STARVE_MAX consecutive data grants taken while it waited.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e state;
    arb_state_e state_nxt;

    logic owner_dm;
    logic grant_dm;
    logic grant_if;
    logic force_if;

    if (STARVE_MAX < 1) begin : g_cfg_check
        $error("pipe_mem_arbiter: STARVE_MAX must be >= 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_guard #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_guard (
        .clk      (clk),
        .rst      (rst),
        .grant_dm (grant_dm),
        .grant_if (grant_if),
        .if_req   (if_req),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req && !(force_if && if_req)) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUSY_DM;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_dm) begin
                owner_dm  <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end
            if (grant_if) begin
                owner_dm <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end
            if (state == BUSY_IF && mem_ready) begin
                if_rdata <= mem_rdata;
            end
            // Writes return no data; keep the last read value.
            if (state == BUSY_DM && mem_ready && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state == BUSY_IF) || (state == BUSY_DM);
    assign if_ack    = (state == RESP) && !owner_dm;
    assign dm_ack    = (state == RESP) && owner_dm;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter with a wait-state memory model
// and per-port expected-data queues.
module tb_pipe_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int NDM  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall_if;
    logic          stall_mem;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    int rsp_cnt = 0;

    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic [DW-1:0] exp_if [$];
    logic [DW-1:0] exp_dm [$];
    logic [DW-1:0] dm_model;

    always #5 clk = ~clk;

    pipe_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: ready after wait_cfg wait cycles of a held request.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (rsp_cnt >= wait_cfg) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = 32'hBAD0_0000;
                    end else begin
                        mem_rdata = mem_data(mem_addr);
                    end
                    rsp_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    rsp_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                rsp_cnt = 0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        dm_model = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mem_ctl got %b want 00", {mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata});
        end
        checks++;
        if ({if_ack, dm_ack, stall_if, stall_mem} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack_stall got %b want 0000",
                     {if_ack, dm_ack, stall_if, stall_mem});
        end
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", {if_rdata, dm_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n = 0;
        bit got = 0;
        bit saw = 0;
        bit bad_stall = 0;
        logic [DW-1:0] e;
        mem_arr[32'h10] = 32'h0050_0093;
        wait_cfg = 1;
        if_addr = 32'h10;
        if_req = 1'b1;
        exp_if.push_back(32'h0050_0093);
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_req && !saw) begin
                saw = 1;
                checks++;
                if ({mem_we, mem_addr} !== {1'b0, 32'h10} || n != 1) begin
                    errors++;
                    $display("FAIL fetch_grant got we=%b addr=%h cyc=%0d want we=0 addr=10 cyc=1",
                             mem_we, mem_addr, n);
                end
            end
            if (if_ack) begin
                got = 1;
                e = exp_if.size() > 0 ? exp_if.pop_front() : 'x;
                checks++;
                if (if_rdata !== e || n != 3) begin
                    errors++;
                    $display("FAIL fetch_ack got %h cyc=%0d want %h cyc=3",
                             if_rdata, n, e);
                end
                if_req = 1'b0;
            end else if (stall_if !== 1'b1) begin
                bad_stall = 1;
            end
        end
        checks++;
        if (!got || bad_stall) begin
            errors++;
            $display("FAIL fetch_progress got ack=%b bad_stall=%b want ack=1 bad_stall=0",
                     got, bad_stall);
        end
        @(negedge clk);
        checks++;
        if ({if_ack, stall_if} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after got ack/stall=%b want 00", {if_ack, stall_if});
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int dm_cyc = 0;
        int if_cyc = 0;
        bit dm_done = 0;
        bit if_done = 0;
        bit bad = 0;
        bit first = 0;
        logic [DW-1:0] e;
        wait_cfg = 0;
        dm_we = 1'b0; dm_addr = 32'h200;
        if_addr = 32'h14;
        dm_req = 1'b1; if_req = 1'b1;
        dm_model = mem_data(32'h200);
        exp_dm.push_back(dm_model);
        exp_if.push_back(mem_data(32'h14));
        while (!if_done && n < 30) begin
            @(negedge clk);
            n++;
            if (mem_req && !first) begin
                first = 1;
                checks++;
                if (mem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL tie_first_grant got %h want 00000200", mem_addr);
                end
            end
            if (!dm_done && stall_if !== 1'b1) bad = 1;
            if (dm_ack) begin
                dm_done = 1; dm_cyc = n;
                e = exp_dm.size() > 0 ? exp_dm.pop_front() : 'x;
                checks++;
                if (dm_rdata !== e) begin
                    errors++;
                    $display("FAIL tie_dm_data got %h want %h", dm_rdata, e);
                end
                dm_req = 1'b0;
            end
            if (if_ack) begin
                if_done = 1; if_cyc = n;
                if (!dm_done) bad = 1;
                e = exp_if.size() > 0 ? exp_if.pop_front() : 'x;
                checks++;
                if (if_rdata !== e) begin
                    errors++;
                    $display("FAIL tie_if_data got %h want %h", if_rdata, e);
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (!if_done || !dm_done || bad || if_cyc - dm_cyc != 3) begin
            errors++;
            $display("FAIL tie_order got done=%b%b bad=%b gap=%0d want 11 0 gap=3",
                     dm_done, if_done, bad, if_cyc - dm_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        int n = 0;
        int held = 0;
        int acks = 0;
        logic [DW-1:0] e;
        wait_cfg = 3;
        dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        dm_req = 1'b1;
        exp_dm.push_back(dm_model);
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_req && mem_we && mem_addr == 32'h40 &&
                mem_wdata == 32'hDEAD_BEEF) held++;
            if (dm_ack) begin
                acks++;
                e = exp_dm.size() > 0 ? exp_dm.pop_front() : 'x;
                checks++;
                if (dm_rdata !== e) begin
                    errors++;
                    $display("FAIL write_rdata_kept got %h want %h", dm_rdata, e);
                end
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end
        checks++;
        if (held != 4 || acks != 1) begin
            errors++;
            $display("FAIL write_hold got held=%0d acks=%0d want held=4 acks=1",
                     held, acks);
        end
        wait_cfg = 0;
        dm_addr = 32'h40; dm_req = 1'b1;
        dm_model = 32'hDEAD_BEEF;
        exp_dm.push_back(dm_model);
        n = 0; acks = 0;
        while (acks == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (dm_ack) begin
                acks++;
                e = exp_dm.size() > 0 ? exp_dm.pop_front() : 'x;
                checks++;
                if (dm_rdata !== e) begin
                    errors++;
                    $display("FAIL write_readback got %h want %h", dm_rdata, e);
                end
                dm_req = 1'b0;
            end
        end
        if (acks == 0) begin
            checks++; errors++;
            $display("FAIL write_readback got timeout want dm_ack");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit ack_seen = 0;
        wait_cfg = 10;
        dm_we = 1'b0; dm_addr = 32'h300; dm_req = 1'b1;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack,
             if_rdata, dm_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got req=%b we=%b addr=%h ack=%b%b rd=%h/%h want all 0",
                     mem_req, mem_we, mem_addr, if_ack, dm_ack, if_rdata, dm_rdata);
        end
        dm_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (dm_ack || mem_req) ack_seen = 1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (dm_ack || mem_req) ack_seen = 1;
        end
        checks++;
        if (ack_seen) begin
            errors++;
            $display("FAIL rst_mid_quiet got ack/req=1 want 0");
        end
        dm_model = '0;
    endtask

    task automatic test_back_to_back_starve();
        int n = 0;
        int k = 0;
        int dm_acks = 0;
        int before_if = -1;
        int last = 0;
        bit bad_gap = 0;
        bit if_done = 0;
        int want;
        logic [DW-1:0] e;
`ifdef ARB_STARVE_GUARD_EN
        want = SMAX;
`else
        want = NDM;
`endif
        wait_cfg = 0;
        if_addr = 32'h20; if_req = 1'b1;
        exp_if.push_back(mem_data(32'h20));
        dm_we = 1'b0; dm_addr = 32'h400; dm_req = 1'b1;
        exp_dm.push_back(mem_data(32'h400));
        while (!(if_done && dm_acks == NDM) && n < 200) begin
            @(negedge clk);
            n++;
            if (dm_ack || if_ack) begin
                if (last != 0 && n - last != 3) bad_gap = 1;
                last = n;
            end
            if (dm_ack) begin
                dm_acks++;
                e = exp_dm.size() > 0 ? exp_dm.pop_front() : 'x;
                checks++;
                if (dm_rdata !== e) begin
                    errors++;
                    $display("FAIL starve_dm_data got %h want %h", dm_rdata, e);
                end
                k++;
                if (k < NDM) begin
                    dm_addr = 32'h400 + 32'(4 * k);
                    exp_dm.push_back(mem_data(dm_addr));
                end else begin
                    dm_req = 1'b0;
                end
            end
            if (if_ack) begin
                if_done = 1;
                before_if = dm_acks;
                e = exp_if.size() > 0 ? exp_if.pop_front() : 'x;
                checks++;
                if (if_rdata !== e) begin
                    errors++;
                    $display("FAIL starve_if_data got %h want %h", if_rdata, e);
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (before_if != want) begin
            errors++;
            $display("FAIL starve_if_slot got %0d dm grants before fetch want %0d",
                     before_if, want);
        end
        checks++;
        if (bad_gap || dm_acks != NDM) begin
            errors++;
            $display("FAIL back_to_back got bad_gap=%b dm_acks=%0d want 0 and %0d",
                     bad_gap, dm_acks, NDM);
        end
        checks++;
        if (exp_if.size() != 0 || exp_dm.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got if=%0d dm=%0d left want 0 0",
                     exp_if.size(), exp_dm.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_write();
        test_reset_mid();
        test_back_to_back_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
